// File: rtl/partial_sum_accumulator.sv
// partial_sum_accumulator
//
// Collects groups of partial-sum pairs from an upstream adder stage into a
// wide unsigned accumulator. When a group closes, the result goes out as three
// RADIX-bit limbs: low, high and guard. A group closes either on a beat with
// in_last set, or when it reaches MAX_BEATS beats. Closing by the beat limit
// sets the sticky err_overflow flag.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      upstream beat valid
//   in_ready      block can accept a beat (ACCUM only; 0 while in reset)
//   in_res_0/1    two 2*RADIX-bit partial sums per beat
//   in_last       final beat of the current group
//   out_valid     output limb valid (EMIT only)
//   out_ready     downstream accepts the limb
//   out_limb      current limb (low, high, or zero-extended guard bits)
//   out_idx       limb index: 0 = low, 1 = high, 2 = guard
//   out_last      guard limb on the output
//   err_overflow  sticky: a group was closed by the beat limit
module partial_sum_accumulator #(
  parameter int RADIX     = 54,
  parameter int GUARD     = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*RADIX-1:0] in_res_0,
  input  logic [2*RADIX-1:0] in_res_1,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADIX-1:0]   out_limb,
  output logic [1:0]         out_idx,
  output logic               out_last,
  output logic               err_overflow
);

  localparam int PS_W  = 2 * RADIX;
  localparam int ACC_W = PS_W + GUARD;
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BEATS - 1);
  localparam logic [1:0]       IDX_GUARD = 2'd2;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;
  // Holds in_ready low until the first clock edge after reset release.
  logic              live_q;

  logic              beat_take;
  logic              limb_take;
  logic [ACC_W-1:0]  beat_sum;

  // Limb selection: the guard bits are zero-extended up to a full limb.
  function automatic logic [RADIX-1:0] limb_sel(input logic [ACC_W-1:0] acc,
                                                input logic [1:0]       idx);
    logic [RADIX-1:0] limb;
    case (idx)
      2'd0:    limb = acc[RADIX-1:0];
      2'd1:    limb = acc[PS_W-1:RADIX];
      2'd2:    limb = RADIX'(acc[ACC_W-1:PS_W]);
      default: limb = '0;
    endcase
    return limb;
  endfunction

  always_comb begin
    in_ready  = (state_q == ACCUM) && live_q;
    out_valid = (state_q == EMIT);
    out_idx   = idx_q;
    out_last  = (state_q == EMIT) && (idx_q == IDX_GUARD);
    out_limb  = limb_sel(acc_q, idx_q);
    err_overflow = err_q;

    beat_take = in_valid && in_ready;
    limb_take = out_valid && out_ready;
    // Both operands are zero-extended first so the carry out of 2*RADIX is kept.
    beat_sum  = ACC_W'(in_res_0) + ACC_W'(in_res_1);

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;

    case (state_q)
      ACCUM: begin
        if (beat_take) begin
          // A zero count marks the first beat, which replaces the old result.
          acc_d = ((cnt_q == '0) ? '0 : acc_q) + beat_sum;
          if (in_last || (cnt_q == CNT_LAST)) begin
            state_d = EMIT;
            idx_d   = '0;
            if (!in_last) err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        if (limb_take) begin
          if (idx_q == IDX_GUARD) begin
            state_d = ACCUM;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ACCUM;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Testbench for partial_sum_accumulator: directed scenarios plus randomized
// groups, checked against a wide-integer reference sum.
module tb_partial_sum_accumulator;

  localparam int RADIX     = 54;
  localparam int GUARD     = 4;
  localparam int MAX_BEATS = 8;
  localparam int PS_W      = 2 * RADIX;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [PS_W-1:0]  in_res_0;
  logic [PS_W-1:0]  in_res_1;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [RADIX-1:0] out_limb;
  logic [1:0]       out_idx;
  logic             out_last;
  logic             err_overflow;

  int   tests_run;
  int   tests_failed;
  logic err_model;
  logic [PS_W-1:0] ones108;

  partial_sum_accumulator #(
    .RADIX(RADIX), .GUARD(GUARD), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_res_0(in_res_0), .in_res_1(in_res_1), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_limb(out_limb), .out_idx(out_idx), .out_last(out_last),
    .err_overflow(err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: limb k of the exact sum, by repeated division by 2^RADIX.
  function automatic logic [RADIX-1:0] exp_limb(input logic [127:0] s, input int k);
    logic [127:0] base;
    logic [127:0] q;
    base = 128'd1 << RADIX;
    q = s;
    for (int j = 0; j < k; j++) q = q / base;
    if (k < 2) q = q % base;
    return q[RADIX-1:0];
  endfunction

  function automatic logic [PS_W-1:0] rand108();
    logic [127:0] r;
    int sel;
    sel = int'($urandom_range(3));
    r = {$urandom, $urandom, $urandom, $urandom};
    if (sel == 0) return ones108;
    if (sel == 1) return PS_W'(r[15:0]);
    return r[PS_W-1:0];
  endfunction

  task automatic send_beat(input logic [PS_W-1:0] a, input logic [PS_W-1:0] b,
                           input logic last, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_res_0 = a; in_res_1 = b; in_last = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Collects three limbs; ok drops on wrong index order, timeout, or
  // in_ready seen high while a limb is pending.
  task automatic drain(input int stall_pct, output logic [2:0][RADIX-1:0] l,
                       output logic [2:0] lf, output int cyc, output bit ok);
    int got;
    got = 0; l = '0; lf = '0; ok = 1'b1; cyc = 0;
    while (got < 3 && cyc < 500) begin
      @(negedge clk);
      out_ready = (int'($urandom_range(99)) >= stall_pct);
      cyc++;
      if (out_valid && in_ready) ok = 1'b0;
      if (out_valid && out_ready) begin
        if (out_idx !== 2'(got)) ok = 1'b0;
        l[got]  = out_limb;
        lf[got] = out_last;
        got++;
      end
    end
    if (got < 3) ok = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b last=%b want 0 0 0", in_ready, out_valid, out_last);
    end
    tests_run++;
    if (out_limb !== '0 || out_idx !== 2'd0 || err_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data got limb=%0h idx=%0d err=%b want 0 0 0", out_limb, out_idx, err_overflow);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_ready got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_edge_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_carry();
    logic [127:0] s;
    logic [2:0][RADIX-1:0] l;
    logic [2:0] lf;
    int cyc;
    bit ok;
    s = 128'(ones108) + 128'd1;
    send_beat(ones108, 108'd1, 1'b1, ok);
    @(negedge clk);
    tests_run++;
    if (!ok || out_valid !== 1'b1 || out_idx !== 2'd0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_latency got acc=%b vld=%b idx=%0d rdy=%b want 1 1 0 0", ok, out_valid, out_idx, in_ready);
    end
    drain(0, l, lf, cyc, ok);
    tests_run++;
    if (!ok || cyc !== 3) begin
      tests_failed++;
      $display("FAIL single_drain got ok=%b cycles=%0d want 1 3", ok, cyc);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (l[k] !== exp_limb(s, k)) begin
        tests_failed++;
        $display("FAIL single_limb%0d got %0h want %0h", k, l[k], exp_limb(s, k));
      end
    end
    tests_run++;
    if (lf !== 3'b100 || err_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_last_err got last=%b err=%b want 100 0", lf, err_overflow);
    end
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_back_to_accum got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_three_beats();
    logic [PS_W-1:0] p54;
    logic [127:0] s;
    logic [2:0][RADIX-1:0] l;
    logic [2:0] lf;
    int cyc;
    bit ok, ok_all;
    p54 = '0; p54[54] = 1'b1;
    s = 128'd5 + 128'd7 + 128'd1 + 128'd1 + 128'(p54);
    ok_all = 1'b1;
    send_beat(108'd5, 108'd7, 1'b0, ok); ok_all &= ok;
    send_beat(108'd1, 108'd1, 1'b0, ok); ok_all &= ok;
    send_beat(p54, 108'd0, 1'b1, ok);    ok_all &= ok;
    drain(30, l, lf, cyc, ok);
    tests_run++;
    if (!ok_all || !ok) begin
      tests_failed++;
      $display("FAIL three_handshake got send=%b drain=%b want 1 1", ok_all, ok);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (l[k] !== exp_limb(s, k)) begin
        tests_failed++;
        $display("FAIL three_limb%0d got %0h want %0h", k, l[k], exp_limb(s, k));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PS_W-1:0] a, b, c, d;
    logic [127:0] s1, s2;
    logic [2:0][RADIX-1:0] l;
    logic [2:0] lf;
    int cyc;
    bit ok;
    a = rand108(); b = rand108(); c = rand108(); d = rand108();
    s1 = 128'(a) + 128'(b);
    s2 = 128'(c) + 128'(d);
    send_beat(a, b, 1'b1, ok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid = 1'b1; in_res_0 = c; in_res_1 = d; in_last = 1'b1; out_ready = 1'b0;
      end
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_limb !== exp_limb(s1, 0) || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold cyc%0d got vld=%b idx=%0d limb=%0h rdy=%b want 1 0 %0h 0",
                 i, out_valid, out_idx, out_limb, in_ready, exp_limb(s1, 0));
      end
    end
    drain(30, l, lf, cyc, ok);
    tests_run++;
    if (!ok || l[0] !== exp_limb(s1, 0) || l[1] !== exp_limb(s1, 1) || l[2] !== exp_limb(s1, 2)) begin
      tests_failed++;
      $display("FAIL stall_first_group got ok=%b limbs=%0h,%0h,%0h want %0h,%0h,%0h", ok, l[0], l[1], l[2],
               exp_limb(s1, 0), exp_limb(s1, 1), exp_limb(s1, 2));
    end
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_ready_after got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_held_beat_closed got vld=%b want 1", out_valid);
    end
    drain(0, l, lf, cyc, ok);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (!ok || l[k] !== exp_limb(s2, k)) begin
        tests_failed++;
        $display("FAIL stall_held_limb%0d got %0h want %0h", k, l[k], exp_limb(s2, k));
      end
    end
  endtask

  task automatic test_random();
    logic [PS_W-1:0] a, b;
    logic [127:0] s;
    logic [2:0][RADIX-1:0] l;
    logic [2:0] lf;
    logic last;
    int cnt, cyc;
    bit ok;
    s = '0; cnt = 0;
    for (int n = 0; n < 60; n++) begin
      a = rand108(); b = rand108();
      last = (int'($urandom_range(99)) < 25) || (n == 59);
      send_beat(a, b, last, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL random_accept beat%0d got not accepted want accepted", n);
      end
      s = s + 128'(a) + 128'(b);
      cnt++;
      if (last || cnt == MAX_BEATS) begin
        if (!last) err_model = 1'b1;
        drain(40, l, lf, cyc, ok);
        for (int k = 0; k < 3; k++) begin
          tests_run++;
          if (!ok || l[k] !== exp_limb(s, k)) begin
            tests_failed++;
            $display("FAIL random_limb%0d beat%0d got %0h want %0h ok=%b", k, n, l[k], exp_limb(s, k), ok);
          end
        end
        tests_run++;
        if (lf !== 3'b100 || err_overflow !== err_model) begin
          tests_failed++;
          $display("FAIL random_last_err beat%0d got last=%b err=%b want 100 %b", n, lf, err_overflow, err_model);
        end
        s = '0; cnt = 0;
      end
    end
  endtask

  task automatic test_overflow();
    logic [127:0] s;
    logic [2:0][RADIX-1:0] l;
    logic [2:0] lf;
    int cyc;
    bit ok;
    s = '0;
    for (int n = 0; n < MAX_BEATS; n++) begin
      send_beat(ones108, ones108, 1'b0, ok);
      s = s + 128'(ones108) + 128'(ones108);
      if (n == MAX_BEATS - 2) begin
        tests_run++;
        if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0 || err_overflow !== err_model) begin
          tests_failed++;
          $display("FAIL ovf_before_limit got ok=%b rdy=%b vld=%b err=%b want 1 1 0 %b",
                   ok, in_ready, out_valid, err_overflow, err_model);
        end
      end
    end
    err_model = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || err_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_close got vld=%b err=%b want 1 1", out_valid, err_overflow);
    end
    drain(20, l, lf, cyc, ok);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (!ok || l[k] !== exp_limb(s, k)) begin
        tests_failed++;
        $display("FAIL ovf_limb%0d got %0h want %0h", k, l[k], exp_limb(s, k));
      end
    end
    send_beat(108'd9, 108'd1, 1'b1, ok);
    drain(0, l, lf, cyc, ok);
    tests_run++;
    if (!ok || l[0] !== 54'd10 || err_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky_next_group got ok=%b limb0=%0h err=%b want 1 a 1", ok, l[0], err_overflow);
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [127:0] s;
    logic [2:0][RADIX-1:0] l;
    logic [2:0] lf;
    int cyc;
    bit ok;
    send_beat(rand108(), rand108(), 1'b1, ok);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
      tests_failed++;
      $display("FAIL rst_mid_setup got vld=%b idx=%0d want 1 1", out_valid, out_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    err_model = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_overflow !== 1'b0 || out_idx !== 2'd0 || out_limb !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_async got vld=%b rdy=%b err=%b idx=%0d limb=%0h want 0 0 0 0 0",
               out_valid, in_ready, err_overflow, out_idx, out_limb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s = 128'd3 + 128'd4;
    send_beat(108'd3, 108'd4, 1'b1, ok);
    drain(0, l, lf, cyc, ok);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (!ok || l[k] !== exp_limb(s, k)) begin
        tests_failed++;
        $display("FAIL rst_mid_next_limb%0d got %0h want %0h", k, l[k], exp_limb(s, k));
      end
    end
    tests_run++;
    if (err_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_err got %b want 0", err_overflow);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; err_model = 1'b0;
    ones108 = '1;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_res_0 = '0; in_res_1 = '0;
    test_reset();
    test_single_carry();
    test_three_beats();
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_mid_emit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
